// File: rtl/binary_game_pkg.sv
// Shared definitions for the binary guessing game: FSM encoding, LFSR tap mask,
// default parameter values and small LFSR helpers.
package binary_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Taps for x^8+x^6+x^5+x^4+1, register bit 7 holds the x^8 term
  localparam logic [7:0] LFSR_TAP_MASK = 8'hB8;

  localparam int unsigned DEFAULT_NUM_ROUNDS     = 10;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1000;
  localparam logic [7:0]  DEFAULT_LFSR_SEED      = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAP_MASK)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1
  function automatic logic [7:0] safe_seed(input logic [7:0] s);
    return (s == 8'h00) ? 8'h01 : s;
  endfunction

endpackage

// File: rtl/game_lfsr.sv
// 8-bit Fibonacci LFSR that supplies round targets; holds its value unless
// told to reload the seed or advance one step.
module game_lfsr
  import binary_game_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_LFSR_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] value
);

  localparam logic [7:0] INIT = safe_seed(SEED);

  logic [7:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = INIT;
    end else if (advance) begin
      lfsr_d = lfsr_step(lfsr_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= INIT;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/play_round_sequencer.sv
// Round sequencer for the guessing game: IDLE -> GEN -> WAIT -> CHECK -> (GEN|DONE).
// Define ROUND_TIMEOUT_EN to enable the per-round WAIT timeout.
module play_round_sequencer
  import binary_game_pkg::*;
#(
  parameter int unsigned NUM_ROUNDS     = DEFAULT_NUM_ROUNDS,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter logic [7:0]  LFSR_SEED      = DEFAULT_LFSR_SEED
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Select,
  input  logic        Quit,
  input  logic [7:0]  userNumber,
  output logic [7:0]  target,
  output logic [7:0]  score,
  output logic [3:0]  round,
  output logic [15:0] timeLeft,
  output logic        hit,
  output logic        miss,
  output logic        q_Idle,
  output logic        q_Gen,
  output logic        q_Wait,
  output logic        q_Check,
  output logic        q_Done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_e     state_q, state_d;
  logic [7:0] score_q, score_d;
  logic [3:0] round_q, round_d;
  logic [7:0] target_q, target_d;
  logic [7:0] answer_q, answer_d;
  logic       answered_q, answered_d;
  logic       lfsr_advance;
  logic [7:0] lfsr_value;
  logic       timeout_now;
  logic       hit_w;
  logic [3:0] round_inc;

  game_lfsr #(
    .SEED(LFSR_SEED)
  ) u_lfsr (
    .clk    (Clk),
    .rst_n  (Reset),
    .load   (1'b0),
    .advance(lfsr_advance),
    .value  (lfsr_value)
  );

  assign hit_w     = (state_q == ST_CHECK) && answered_q && (answer_q == target_q);
  assign round_inc = round_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    score_d      = score_q;
    round_d      = round_q;
    target_d     = target_q;
    answer_d     = answer_q;
    answered_d   = answered_q;
    lfsr_advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_GEN;
          score_d = '0;
          round_d = '0;
        end
      end
      ST_GEN: begin
        if (Quit) begin
          state_d = ST_DONE;
        end else begin
          target_d     = lfsr_value;
          lfsr_advance = 1'b1;
          answered_d   = 1'b0;
          state_d      = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Quit beats an answer, and an answer beats a simultaneous timeout
        if (Quit) begin
          state_d = ST_DONE;
        end else if (Select) begin
          answer_d   = userNumber;
          answered_d = 1'b1;
          state_d    = ST_CHECK;
        end else if (timeout_now) begin
          answered_d = 1'b0;
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (Quit) begin
          state_d = ST_DONE;
        end else begin
          round_d = round_inc;
          if (hit_w && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
          end
          state_d = (round_inc == LAST_ROUND) ? ST_DONE : ST_GEN;
        end
      end
      ST_DONE: begin
        if (Select) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      round_q    <= '0;
      target_q   <= '0;
      answer_q   <= '0;
      answered_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      round_q    <= round_d;
      target_q   <= target_d;
      answer_q   <= answer_d;
      answered_q <= answered_d;
    end
  end

`ifdef ROUND_TIMEOUT_EN
  localparam logic [15:0] TIME_INIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] time_left_q, time_left_d;

  always_comb begin
    time_left_d = time_left_q;
    if ((state_q == ST_GEN) && !Quit) begin
      time_left_d = TIME_INIT;
    end else if ((state_q == ST_WAIT) && !Quit && !Select && (time_left_q != 16'd0)) begin
      time_left_d = time_left_q - 16'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      time_left_q <= '0;
    end else begin
      time_left_q <= time_left_d;
    end
  end

  assign timeout_now = (time_left_q == 16'd0);
  assign timeLeft    = time_left_q;
`else
  assign timeout_now = 1'b0;
  assign timeLeft    = '0;
`endif

  assign target  = target_q;
  assign score   = score_q;
  assign round   = round_q;
  assign hit     = hit_w;
  assign miss    = (state_q == ST_CHECK) && !hit_w;
  assign q_Idle  = (state_q == ST_IDLE);
  assign q_Gen   = (state_q == ST_GEN);
  assign q_Wait  = (state_q == ST_WAIT);
  assign q_Check = (state_q == ST_CHECK);
  assign q_Done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_play_round_sequencer.sv
// Directed bench for play_round_sequencer; hit/miss expectations are queued when
// a guess is driven and popped when the sequencer reaches CHECK.
module tb_play_round_sequencer;

  localparam int NR = 3;
  localparam int TO = 4;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Start = 1'b0;
  logic        Select = 1'b0;
  logic        Quit = 1'b0;
  logic [7:0]  userNumber = 8'h00;
  logic [7:0]  target;
  logic [7:0]  score;
  logic [3:0]  round;
  logic [15:0] timeLeft;
  logic        hit, miss;
  logic        q_Idle, q_Gen, q_Wait, q_Check, q_Done;

  int errors = 0;
  int checks = 0;

  logic       exp_hit_q[$];
  logic       sb_exp;
  logic [7:0] model_lfsr;
  logic [7:0] exp_target;

  play_round_sequencer #(
    .NUM_ROUNDS    (NR),
    .TIMEOUT_CYCLES(TO),
    .LFSR_SEED     (8'hA5)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Select    (Select),
    .Quit      (Quit),
    .userNumber(userNumber),
    .target    (target),
    .score     (score),
    .round     (round),
    .timeLeft  (timeLeft),
    .hit       (hit),
    .miss      (miss),
    .q_Idle    (q_Idle),
    .q_Gen     (q_Gen),
    .q_Wait    (q_Wait),
    .q_Check   (q_Check),
    .q_Done    (q_Done)
  );

  always #5 Clk = ~Clk;

  // Reference LFSR: x^8+x^6+x^5+x^4+1, feedback from bits 7,5,4,3
  function automatic logic [7:0] ref_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic st, input logic sel, input logic qt, input logic [7:0] num);
    Start      = st;
    Select     = sel;
    Quit       = qt;
    userNumber = num;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // From GEN: step into WAIT and check the freshly loaded target and timer
  task automatic enter_wait();
    check_output("pre_gen", {15'd0, q_Gen}, 16'd1);
    tick();
    exp_target = model_lfsr;
    model_lfsr = ref_next(model_lfsr);
    check_output("wait_entry", {15'd0, q_Wait}, 16'd1);
    check_output("target", {8'd0, target}, {8'd0, exp_target});
`ifdef ROUND_TIMEOUT_EN
    check_output("time_init", timeLeft, 16'(TO - 1));
`else
    check_output("time_tied", timeLeft, 16'd0);
`endif
  endtask

  task automatic answer(input logic [7:0] guess, input logic expect_hit);
    apply_stimulus(1'b0, 1'b1, 1'b0, guess);
    exp_hit_q.push_back(expect_hit);
  endtask

  task automatic check_score_round(input logic [7:0] s, input logic [3:0] r);
    check_output("score", {8'd0, score}, {8'd0, s});
    check_output("round", {12'd0, round}, {12'd0, r});
  endtask

  always @(negedge Clk) begin
    check_output("onehot", 16'($countones({q_Idle, q_Gen, q_Wait, q_Check, q_Done})), 16'd1);
    if (Reset && q_Check) begin
      checks++;
      assert (exp_hit_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL sb_unexpected_check: observed CHECK with %0d queued expected none", exp_hit_q.size());
      end
      if (exp_hit_q.size() != 0) begin
        sb_exp = exp_hit_q.pop_front();
        check_output("sb_hit", {15'd0, hit}, {15'd0, sb_exp});
        check_output("sb_miss", {15'd0, miss}, {15'd0, !sb_exp});
      end
    end else begin
      check_output("quiet_hit", {15'd0, hit}, 16'd0);
      check_output("quiet_miss", {15'd0, miss}, 16'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] start");
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    Reset = 1'b0;
    repeat (2) tick();
    check_output("rst_idle", {15'd0, q_Idle}, 16'd1);
    check_output("rst_target", {8'd0, target}, 16'd0);
    check_score_round(8'd0, 4'd0);
    check_output("rst_time", timeLeft, 16'd0);
    Reset = 1'b1;
    tick();
    check_output("post_rst_idle", {15'd0, q_Idle}, 16'd1);
    model_lfsr = 8'hA5;

    // Session 1: three correct answers ending in DONE
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    check_score_round(8'd0, 4'd0);
    for (int r = 0; r < NR; r++) begin
      enter_wait();
      if (r == 0) check_output("first_target", {8'd0, target}, 16'h00A5);
      answer(exp_target, 1'b1);
      tick();
      check_output("in_check", {15'd0, q_Check}, 16'd1);
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      if (r < NR - 1) check_output("next_gen", {15'd0, q_Gen}, 16'd1);
      else            check_output("to_done", {15'd0, q_Done}, 16'd1);
      check_score_round(8'(r + 1), 4'(r + 1));
    end
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("done_ignores_start", {15'd0, q_Done}, 16'd1);
    check_score_round(8'd3, 4'd3);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check_output("done_ack_idle", {15'd0, q_Idle}, 16'd1);
    check_score_round(8'd3, 4'd3);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // Session 2: wrong guess, then Quit+Select in round 2
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    check_score_round(8'd0, 4'd0);
    enter_wait();
    answer(8'h00, 1'b0);
    tick();
    check_output("miss_check", {15'd0, q_Check}, 16'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("after_miss_gen", {15'd0, q_Gen}, 16'd1);
    check_score_round(8'd0, 4'd1);
    enter_wait();
    apply_stimulus(1'b0, 1'b1, 1'b1, exp_target);
    tick();
    check_output("quit_done", {15'd0, q_Done}, 16'd1);
    check_score_round(8'd0, 4'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    check_output("quit_ack_idle", {15'd0, q_Idle}, 16'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);

    // Session 3: timeout behaviour (or indefinite wait when disabled)
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    enter_wait();
`ifdef ROUND_TIMEOUT_EN
    for (int k = TO - 2; k >= 0; k--) begin
      tick();
      check_output("count_wait", {15'd0, q_Wait}, 16'd1);
      check_output("count_time", timeLeft, 16'(k));
    end
    exp_hit_q.push_back(1'b0);
    tick();
    check_output("timeout_check", {15'd0, q_Check}, 16'd1);
    tick();
    check_output("timeout_gen", {15'd0, q_Gen}, 16'd1);
    check_score_round(8'd0, 4'd1);
    enter_wait();
    repeat (TO - 1) tick();
    check_output("edge_wait", {15'd0, q_Wait}, 16'd1);
    check_output("edge_time", timeLeft, 16'd0);
    answer(exp_target, 1'b1);
    tick();
    check_output("edge_check", {15'd0, q_Check}, 16'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("edge_gen", {15'd0, q_Gen}, 16'd1);
    check_score_round(8'd1, 4'd2);
`else
    repeat (10) tick();
    check_output("long_wait", {15'd0, q_Wait}, 16'd1);
    check_output("long_time", timeLeft, 16'd0);
    answer(exp_target, 1'b1);
    tick();
    check_output("long_check", {15'd0, q_Check}, 16'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("long_gen", {15'd0, q_Gen}, 16'd1);
    check_score_round(8'd1, 4'd1);
`endif

    // Asynchronous reset in WAIT, checked before any clock edge
    enter_wait();
    #2 Reset = 1'b0;
    #1;
    check_output("arst_idle", {15'd0, q_Idle}, 16'd1);
    check_output("arst_target", {8'd0, target}, 16'd0);
    check_score_round(8'd0, 4'd0);
    check_output("arst_time", timeLeft, 16'd0);
    check_output("arst_hit", {15'd0, hit}, 16'd0);
    check_output("arst_miss", {15'd0, miss}, 16'd0);
    tick();
    Reset = 1'b1;
    model_lfsr = 8'hA5;
    tick();
    check_output("rerst_idle", {15'd0, q_Idle}, 16'd1);

    // Session 4: LFSR restarted from the seed
    apply_stimulus(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    enter_wait();
    check_output("reseed_target", {8'd0, target}, 16'h00A5);
    answer(8'hA5, 1'b1);
    tick();
    check_output("reseed_check", {15'd0, q_Check}, 16'd1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'h00);
    tick();
    check_output("reseed_gen", {15'd0, q_Gen}, 16'd1);
    check_score_round(8'd1, 4'd1);

    check_output("sb_drained", 16'(exp_hit_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/play_round_sequencer.md
PLAY_ROUND_SEQUENCER -- requirements
Module: play_round_sequencer

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, SHALL set rounds per session (range 1..15).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000, SHALL set the maximum WAIT cycles per round (range 2..65535).
REQ-003 Parameter LFSR_SEED, default 8'hA5, SHALL set the first target; a zero value SHALL be replaced by 8'h01.
REQ-004 Clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  begins a session when in IDLE.
REQ-007 Select  input  1  submits userNumber in WAIT; acknowledges DONE.
REQ-008 Quit  input  1  aborts the session.
REQ-009 userNumber  input  8  player's guess.
REQ-010 target  output  8  current round's target number.
REQ-011 score  output  8  correct answers this session.
REQ-012 round  output  4  rounds completed this session.
REQ-013 timeLeft  output  16  WAIT cycles remaining.
REQ-014 hit, miss  output  1 each  result strobes for the current round.
REQ-015 q_Idle, q_Gen, q_Wait, q_Check, q_Done  output  1 each  one-hot state indicators.

Function
REQ-016 The FSM SHALL have exactly the states IDLE, GEN, WAIT, CHECK and DONE, and exactly one q_* output SHALL be high at any time.
REQ-017 IDLE with Start=1 SHALL go to GEN and clear score and round; otherwise IDLE SHALL hold.
REQ-018 GEN SHALL last one cycle and SHALL load target from the LFSR, advance the LFSR, load timeLeft with TIMEOUT_CYCLES-1, and go to WAIT.
REQ-019 WAIT with Select=1 SHALL capture userNumber and go to CHECK on the next edge.
REQ-020 WAIT with Select=0 and timeLeft=0 SHALL go to CHECK as a forced miss; otherwise timeLeft SHALL decrement by 1 per cycle.
REQ-021 Select and timeout in the same cycle SHALL count as an answer, not a timeout.
REQ-022 CHECK SHALL last one cycle; hit=1 iff the answer was captured and equals target, else miss=1; hit and miss SHALL be 0 outside CHECK.
REQ-023 On leaving CHECK, round SHALL increment, and score SHALL increment on a hit, saturating at 255.
REQ-024 CHECK SHALL go to DONE if the incremented round equals NUM_ROUNDS, else to GEN.
REQ-025 Quit=1 in GEN, WAIT or CHECK SHALL go to DONE next edge, discarding the pending round (no score or round update).
REQ-026 Quit has priority over Select and over timeout.
REQ-027 DONE SHALL hold score and round; Select=1 SHALL return to IDLE; Start SHALL be ignored.
REQ-028 The LFSR SHALL be 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, never reach zero, and persist across sessions (reset only by Reset).
REQ-029 Latency SHALL be: Select in WAIT to hit/miss = 1 cycle; Start to the first WAIT cycle = 2 cycles.

Reset
REQ-030 Reset=0 SHALL immediately force IDLE, target=0, score=0, round=0, timeLeft=0, hit=miss=0, and LFSR=LFSR_SEED.
REQ-031 Reset asserted mid-session SHALL abandon the session without a CHECK or DONE visit.

Configuration
REQ-032 With ROUND_TIMEOUT_EN defined, REQ-020/021 SHALL apply as written.
REQ-033 Without ROUND_TIMEOUT_EN, WAIT SHALL wait indefinitely for Select or Quit, no timeout miss SHALL occur, and timeLeft SHALL be tied to 0.

Structure
REQ-034 A shared package binary_game_pkg SHALL hold the state encoding, the LFSR tap mask constant and the default parameter constants.
REQ-035 The LFSR SHALL be a separate sub-module game_lfsr with load and advance controls.

Verification
REQ-036 Reset, then Start, wait for WAIT, userNumber=8'hA5 with Select -> target=8'hA5, hit=1 in CHECK, then score=1, round=1.
REQ-037 Wrong guess 8'h00 in round 1 -> miss=1, score=0, round=1, FSM in GEN.
REQ-038 ROUND_TIMEOUT_EN, TIMEOUT_CYCLES=4, no Select -> exactly 4 WAIT cycles, then CHECK with miss=1; Select on the timeLeft=0 cycle with a correct guess -> hit=1.
REQ-039 NUM_ROUNDS=3, all correct -> DONE with score=3, round=3; Select -> IDLE; Start in DONE ignored.
REQ-040 Quit and Select together in WAIT of round 2 -> DONE, round=1, no hit/miss pulse.
REQ-041 Reset=0 asserted in WAIT -> outputs zero without waiting for a clock edge; next session round 1 target=8'hA5.
